// File: rtl/data_memory_if.sv
// Load/store port between the memory-access stage (master) and data_memory (slave).
interface data_memory_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] address_to_main_memory;
  logic              data_to_memory_write_en;
  logic [DATA_W-1:0] data_to_main_memory;
  logic [DATA_W-1:0] data_from_main_memory;
  logic              mem_ready;

  modport master (
    output address_to_main_memory,
    output data_to_memory_write_en,
    output data_to_main_memory,
    input  data_from_main_memory,
    input  mem_ready
  );

  modport slave (
    input  address_to_main_memory,
    input  data_to_memory_write_en,
    input  data_to_main_memory,
    output data_from_main_memory,
    output mem_ready
  );
endinterface

// File: rtl/data_memory.sv
// Main data memory: combinational read, synchronous write, DEPTH x DATA_W array.
// Define DATA_MEM_CLEAR_EN to compile in the reset-time zeroing sweep gated by mem_ready.
module data_memory #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 256
) (
  input  logic            clk,
  input  logic            rst_n,
  data_memory_if.slave    bus
);

  logic [DATA_W-1:0] mem [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic              ready;

`ifdef DATA_MEM_CLEAR_EN

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] clr_idx;
  logic [ADDR_W-1:0] clr_idx_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  // The sweep owns the write port in CLEAR; user writes only reach it in READY.
  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    mem_we      = 1'b0;
    mem_waddr   = bus.address_to_main_memory;
    mem_wdata   = bus.data_to_main_memory;
    case (state)
      CLEAR: begin
        mem_we      = 1'b1;
        mem_waddr   = clr_idx;
        mem_wdata   = '0;
        clr_idx_nxt = clr_idx + 1'b1;
        if (clr_idx == ADDR_W'(DEPTH - 1)) begin
          state_nxt = READY;
        end
      end
      READY: begin
        mem_we = bus.data_to_memory_write_en;
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  // ready is a decode of the state register alone, so it is glitch-free and registered.
  assign ready = (state == READY);

  always_comb begin
    bus.data_from_main_memory = '0;
    if (ready) begin
      bus.data_from_main_memory = mem[bus.address_to_main_memory];
    end
  end

`else

  logic unused_rst_n;
  assign unused_rst_n = rst_n;

  assign ready     = 1'b1;
  assign mem_we    = bus.data_to_memory_write_en;
  assign mem_waddr = bus.address_to_main_memory;
  assign mem_wdata = bus.data_to_main_memory;

  assign bus.data_from_main_memory = mem[bus.address_to_main_memory];

`endif

  assign bus.mem_ready = ready;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

`ifndef SYNTHESIS
  a_we_known: assert property (@(posedge clk) ready |-> !$isunknown(bus.data_to_memory_write_en));
`endif

endmodule

// File: tb/tb_data_memory.sv
// Randomized self-checking bench for data_memory against an array reference model.
module tb_data_memory;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 256;

  logic clk;
  logic rst_n;

  data_memory_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  data_memory #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] model [DEPTH];
  bit                known [DEPTH];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    bus.address_to_main_memory  = a;
    bus.data_to_main_memory     = d;
    bus.data_to_memory_write_en = 1'b1;
    edge_step();
    bus.data_to_memory_write_en = 1'b0;
    model[a] = d;
    known[a] = 1'b1;
  endtask

  task automatic read_check(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
    bus.address_to_main_memory = a;
    #1;
    check(tag, 32'(bus.data_from_main_memory), 32'(exp));
  endtask

`ifdef DATA_MEM_CLEAR_EN
  // Counts edges from reset release; a write is attempted on sweep cycle 3 and
  // optionally reset is pulsed after edge reset_at, which restarts the count.
  task automatic sweep(input int reset_at);
    bit did_reset = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (k == 3) begin
        bus.address_to_main_memory  = 8'h05;
        bus.data_to_main_memory     = 16'hAAAA;
        bus.data_to_memory_write_en = 1'b1;
      end
      edge_step();
      bus.data_to_memory_write_en = 1'b0;
      check("sweep_ready", 32'(bus.mem_ready), 32'(k == DEPTH));
      if (k < DEPTH) check("sweep_rdata", 32'(bus.data_from_main_memory), 32'h0);
      if (k == reset_at && !did_reset) begin
        did_reset = 1'b1;
        rst_n = 1'b0;
        #2;
        check("midclr_ready", 32'(bus.mem_ready), 32'h0);
        edge_step();
        check("midclr_hold", 32'(bus.mem_ready), 32'h0);
        rst_n = 1'b1;
        k = 0;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      model[i] = '0;
      known[i] = 1'b1;
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              we;

    for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;
    bus.address_to_main_memory  = '0;
    bus.data_to_main_memory     = '0;
    bus.data_to_memory_write_en = 1'b0;
    rst_n = 1'b0;
    repeat (3) edge_step();

`ifdef DATA_MEM_CLEAR_EN
    check("rst_ready", 32'(bus.mem_ready), 32'h0);
    check("rst_rdata", 32'(bus.data_from_main_memory), 32'h0);
    rst_n = 1'b1;
    sweep(0);
    // Fill with garbage, then reset: the sweep must erase it, including the
    // attempted write to 0x05 and a reset pulsed mid-sweep.
    write_word(8'h00, 16'hDEAD);
    write_word(8'h7F, 16'hCAFE);
    write_word(8'hFF, 16'hF00D);
    write_word(8'h05, 16'h5A5A);
    rst_n = 1'b0;
    #2;
    check("rst2_ready", 32'(bus.mem_ready), 32'h0);
    edge_step();
    rst_n = 1'b1;
    sweep(100);
    read_check("clr_00", 8'h00, 16'h0000);
    read_check("clr_7f", 8'h7F, 16'h0000);
    read_check("clr_ff", 8'hFF, 16'h0000);
    read_check("clr_05", 8'h05, 16'h0000);
`else
    check("rst_ready", 32'(bus.mem_ready), 32'h1);
    rst_n = 1'b1;
    edge_step();
    check("post_rst_ready", 32'(bus.mem_ready), 32'h1);
`endif

    // Write/read with old value visible until the edge.
    write_word(8'h12, 16'h5555);
    write_word(8'h13, 16'h1313);
    bus.address_to_main_memory  = 8'h12;
    bus.data_to_main_memory     = 16'hBEEF;
    bus.data_to_memory_write_en = 1'b1;
    #2;
    check("rdw_old", 32'(bus.data_from_main_memory), 32'h5555);
    edge_step();
    bus.data_to_memory_write_en = 1'b0;
    model[8'h12] = 16'hBEEF;
    check("rdw_new", 32'(bus.data_from_main_memory), 32'hBEEF);
    read_check("neighbor", 8'h13, 16'h1313);

    // Back-to-back writes to the top address.
    write_word(8'hFF, 16'h1111);
    write_word(8'hFF, 16'h2222);
    read_check("b2b_ff", 8'hFF, 16'h2222);
    read_check("b2b_12", 8'h12, 16'hBEEF);

    // Random traffic against the array model.
    for (int n = 0; n < 600; n++) begin
      a  = ($urandom_range(0, 3) == 0) ? ADDR_W'($urandom_range(0, 7)) : ADDR_W'($urandom_range(0, DEPTH - 1));
      d  = DATA_W'($urandom);
      we = ($urandom_range(0, 1) == 1);
      bus.address_to_main_memory  = a;
      bus.data_to_main_memory     = d;
      bus.data_to_memory_write_en = we;
      #2;
      if (known[a]) check("rand_pre", 32'(bus.data_from_main_memory), 32'(model[a]));
      edge_step();
      if (we) begin
        model[a] = d;
        known[a] = 1'b1;
      end
      if (known[a]) check("rand_post", 32'(bus.data_from_main_memory), 32'(model[a]));
    end
    bus.data_to_memory_write_en = 1'b0;
    check("ready_steady", 32'(bus.mem_ready), 32'h1);

    // Reset in READY.
    write_word(8'h40, 16'h1234);
    bus.address_to_main_memory = 8'h40;
    rst_n = 1'b0;
    #2;
`ifdef DATA_MEM_CLEAR_EN
    check("rst_ready_drop", 32'(bus.mem_ready), 32'h0);
    check("rst_rdata_zero", 32'(bus.data_from_main_memory), 32'h0);
    edge_step();
    rst_n = 1'b1;
    sweep(0);
    read_check("after_rst_40", 8'h40, 16'h0000);
`else
    check("rst_ready_hold", 32'(bus.mem_ready), 32'h1);
    check("rst_rdata_live", 32'(bus.data_from_main_memory), 32'h1234);
    edge_step();
    check("rst_ready_hold2", 32'(bus.mem_ready), 32'h1);
    rst_n = 1'b1;
    edge_step();
    read_check("after_rst_40", 8'h40, 16'h1234);
    read_check("after_rst_ff", 8'hFF, model[8'hFF]);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
